// File: rtl/jp_responder.sv
// jp_responder: device end of the NES joypad serial protocol.
// Latch parallel-loads the staged buttons, jp_clk shifts them out active-low.
module jp_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 50000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] btn_in,
    input  logic       btn_wr_in,
    input  logic       jp_latch_in,
    input  logic       jp_clk_in,
    output logic       jp_data_out,
    output logic       busy_out,
    output logic [7:0] latch_cnt_out
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    localparam logic [15:0] TMO_LD = 16'(IDLE_TIMEOUT - 1);

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] lat_sync, clk_sync;
    logic lat_s, clk_s;
    logic lat_q, clk_q;
    logic lat_fall_q, clk_rise_q;

    logic [7:0]  btn_stage;
    logic [7:0]  sreg, sreg_n;
    logic [3:0]  bit_cnt, cnt_n;
    logic [15:0] tmr, tmr_n;
    logic [7:0]  lcnt_n;
    logic        data_n;

    assign lat_s    = lat_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign busy_out = (state != IDLE);

    // Edge pulses are registered so every master event costs the same latency.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lat_sync   <= '0;
            clk_sync   <= '0;
            lat_q      <= 1'b0;
            clk_q      <= 1'b0;
            lat_fall_q <= 1'b0;
            clk_rise_q <= 1'b0;
        end else begin
            lat_sync   <= {lat_sync[SYNC_STAGES-2:0], jp_latch_in};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], jp_clk_in};
            lat_q      <= lat_s;
            clk_q      <= clk_s;
            lat_fall_q <= lat_q & ~lat_s;
            clk_rise_q <= ~clk_q & clk_s;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            btn_stage <= '0;
        end else if (btn_wr_in) begin
            btn_stage <= btn_in;
        end
    end

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = bit_cnt;
        tmr_n   = tmr;
        lcnt_n  = latch_cnt_out;
        unique case (state)
            IDLE: begin
                if (lat_q) begin
                    state_n = LOAD;
                    sreg_n  = btn_stage;
                    cnt_n   = '0;
                end
            end
            LOAD: begin
                sreg_n = btn_stage;
                cnt_n  = '0;
                if (lat_fall_q) begin
                    state_n = SHIFT;
                    lcnt_n  = latch_cnt_out + 8'd1;
                    tmr_n   = TMO_LD;
                end
            end
            SHIFT: begin
                if (lat_q) begin
                    state_n = LOAD;
                    sreg_n  = btn_stage;
                    cnt_n   = '0;
                end else if (clk_rise_q) begin
                    tmr_n = TMO_LD;
                    if (!bit_cnt[3]) begin
                        sreg_n = {1'b0, sreg[7:1]};
                        cnt_n  = bit_cnt + 4'd1;
                    end
                end else if (tmr == 16'd0) begin
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line tracks the staging register during LOAD; pads read 1s past bit 8.
    always_comb begin
        data_n = 1'b1;
        unique case (1'b1)
            (state == LOAD):  data_n = ~btn_stage[0];
            (state == SHIFT): data_n = bit_cnt[3] ? 1'b0 : ~sreg[0];
            default:          data_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            sreg          <= '0;
            bit_cnt       <= '0;
            tmr           <= '0;
            latch_cnt_out <= '0;
            jp_data_out   <= 1'b1;
        end else begin
            state         <= state_n;
            sreg          <= sreg_n;
            bit_cnt       <= cnt_n;
            tmr           <= tmr_n;
            latch_cnt_out <= lcnt_n;
            jp_data_out   <= data_n;
        end
    end
endmodule
